// File: rtl/cluster_event_rx_if.sv
// Event channel bundle between the SoC-side sender, this receiver and the event consumer.
// Latency: none, wires only.
// Backpressure: evt_ready_i stalls the consumer side; the sender is throttled by the returned read pointer.
interface cluster_event_rx_if #(
    parameter int BUFFER_WIDTH = 8,
    parameter int EVNT_WIDTH   = 8
);
    logic [BUFFER_WIDTH-1:0] events_wt_i;
    logic [BUFFER_WIDTH-1:0] events_rp_o;
    logic [EVNT_WIDTH-1:0]   events_da_i;
    logic                    evt_valid_o;
    logic [EVNT_WIDTH-1:0]   evt_data_o;
    logic                    evt_ready_i;
    logic [15:0]             evt_cnt_o;
    logic                    clear_cnt_i;
    logic                    token_err_o;

    // Receiver side.
    modport slave (
        input  events_wt_i, events_da_i, evt_ready_i, clear_cnt_i,
        output events_rp_o, evt_valid_o, evt_data_o, evt_cnt_o, token_err_o
    );

    // Sender plus consumer side (driver of the receiver inputs).
    modport master (
        output events_wt_i, events_da_i, evt_ready_i, clear_cnt_i,
        input  events_rp_o, evt_valid_o, evt_data_o, evt_cnt_o, token_err_o
    );
endinterface

// File: rtl/cluster_event_rx.sv
// Receive side of a Johnson-token clock-domain-crossing event channel; single output register stage.
// Latency: SYNC_STAGES+1 clk_i edges from a write-token change to evt_valid_o with the output empty.
// Backpressure: evt_ready_i low holds the output event; no further pops until it is accepted.
module cluster_event_rx #(
    parameter int BUFFER_WIDTH = 8,
    parameter int EVNT_WIDTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    cluster_event_rx_if.slave  evt_if
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    localparam logic [BUFFER_WIDTH-2:0] TRANS_ONE = 1;
    localparam logic [15:0]             CNT_MAX   = 16'hFFFF;

    logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] rp_q, rp_d;
    logic [EVNT_WIDTH-1:0]   data_q, data_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    err_q, err_d;
    state_e                  state_q, state_d;

    logic [BUFFER_WIDTH-1:0] wt_sync;
    logic [BUFFER_WIDTH-2:0] wt_trans;
    logic                    wt_legal;
    logic                    valid;
    logic                    handshake;
    logic                    pop;

    // One Johnson step: shift left, new LSB is the inverted old MSB.
    function automatic logic [BUFFER_WIDTH-1:0] johnson_step(input logic [BUFFER_WIDTH-1:0] code);
        return {code[BUFFER_WIDTH-2:0], ~code[BUFFER_WIDTH-1]};
    endfunction

    // Synchronizer chain: the only consumer of the asynchronous write token.
    always_comb begin
        sync_d[0] = evt_if.events_wt_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign wt_sync = sync_q[SYNC_STAGES-1];

    // A legal Johnson code has at most one boundary between adjacent differing bits.
    assign wt_trans  = wt_sync[BUFFER_WIDTH-1:1] ^ wt_sync[BUFFER_WIDTH-2:0];
    assign wt_legal  = ((wt_trans & (wt_trans - TRANS_ONE)) == '0);

    assign valid     = (state_q == S_HOLD);
    assign handshake = valid & evt_if.evt_ready_i;
    assign pop       = (wt_sync != rp_q) && (!valid || evt_if.evt_ready_i) && wt_legal;

    // Next-state for the output stage, read pointer, delivery counter and error flag.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        err_d   = err_q | ~wt_legal;

        if (pop) begin
            data_d  = evt_if.events_da_i;
            rp_d    = johnson_step(rp_q);
            state_d = S_HOLD;
        end else if (handshake) begin
            state_d = S_IDLE;
        end

        // A clear coinciding with a delivery still counts that delivery.
        if (evt_if.clear_cnt_i) begin
            cnt_d = handshake ? 16'd1 : 16'd0;
        end else if (handshake && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers; reset discards any event in flight and restarts the token at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            rp_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            rp_q    <= rp_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign evt_if.events_rp_o = rp_q;
    assign evt_if.evt_valid_o = valid;
    assign evt_if.evt_data_o  = data_q;
    assign evt_if.evt_cnt_o   = cnt_q;
    assign evt_if.token_err_o = err_q;

endmodule
